// File: rtl/tdm_skener.sv
// Scan sequencer / deserializer for a tristate channel multiplexer: steps the
// mux address once per slot, samples its output, and emits one word per frame.
module tdm_skener #(
  parameter int N_KAN    = 4,
  parameter int ADR_W    = 2,
  parameter int SLOT_CIK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kont,
  input  logic             stop,
  input  logic             inf_ul,
  output logic [ADR_W-1:0] adr_ul,
  output logic [N_KAN-1:0] rijec,
  output logic             valid,
  output logic             zauzet
);

  localparam int CNT_W = (SLOT_CIK > 1) ? $clog2(SLOT_CIK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CIK - 1);
  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(N_KAN - 1);

  typedef enum logic {MIR, SLOT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [N_KAN-1:0]   buf_q, buf_d, buf_mrg;
  logic [N_KAN-1:0]   rijec_q, rijec_d;
  logic               stop_q, stop_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MIR;
      cnt_q   <= '0;
      adr_q   <= '0;
      buf_q   <= '0;
      rijec_q <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      buf_q   <= buf_d;
      rijec_q <= rijec_d;
      stop_q  <= stop_d;
      valid_q <= valid_d;
    end
  end

  // Capture buffer with the bit of the current slot merged in.
  always_comb begin
    buf_mrg = buf_q;
    for (int i = 0; i < N_KAN; i++)
      if (adr_q == ADR_W'(i)) buf_mrg[i] = inf_ul;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    buf_d   = buf_q;
    rijec_d = rijec_q;
    stop_d  = stop_q;
    valid_d = 1'b0;
    case (state_q)
      MIR: begin
        if (start) begin
          state_d = SLOT;
          cnt_d   = '0;
          adr_d   = '0;
          buf_d   = '0;
          stop_d  = 1'b0;
        end
      end
      SLOT: begin
        stop_d = stop_q | stop;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          buf_d = buf_mrg;
          if (adr_q != ADR_LAST) begin
            adr_d = adr_q + ADR_W'(1);
          end else begin
            // Frame end: a stop seen on this very edge still ends the scan.
            rijec_d = buf_mrg;
            valid_d = 1'b1;
            adr_d   = '0;
            buf_d   = '0;
            stop_d  = 1'b0;
            if (!(kont && !(stop_q || stop))) state_d = MIR;
          end
        end
      end
      default: state_d = MIR;
    endcase
  end

  assign adr_ul = adr_q;
  assign rijec  = rijec_q;
  assign valid  = valid_q;
  assign zauzet = (state_q == SLOT);

endmodule

// File: tb/tb_tdm_skener.sv
// Directed bench: a 4-channel/2-cycle scanner and a 3-channel/1-cycle scanner,
// each driven by a tiny mux model (inf_ul = pattern bit at the current address).
module tb_tdm_skener;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, kontA, stopA;
  logic [3:0] patA;
  logic [1:0] adrA;
  logic [3:0] rijecA;
  logic       validA, zauA;
  logic       startB, kontB, stopB;
  logic [3:0] patB;
  logic [1:0] adrB;
  logic [2:0] rijecB;
  logic       validB, zauB;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tdm_skener #(.N_KAN(4), .ADR_W(2), .SLOT_CIK(2)) dutA (
    .clk(clk), .rst(rst), .start(startA), .kont(kontA), .stop(stopA),
    .inf_ul(patA[adrA]), .adr_ul(adrA), .rijec(rijecA), .valid(validA), .zauzet(zauA));

  tdm_skener #(.N_KAN(3), .ADR_W(2), .SLOT_CIK(1)) dutB (
    .clk(clk), .rst(rst), .start(startB), .kont(kontB), .stop(stopB),
    .inf_ul(patB[adrB]), .adr_ul(adrB), .rijec(rijecB), .valid(validB), .zauzet(zauB));

  typedef struct {
    logic       start, stop;
    logic [1:0] adr;
    logic       vld, zau;
    logic [3:0] rij;
  } vec_t;
  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Expected A-side outputs after edge e of a scan started at edge 0 that
  // finishes on edge 'last' (4 channels x 2 cycles => 8 edges per frame).
  task automatic chk_a(input string nm, input int e, input int last);
    int ea, ev, ez;
    if (e > last) begin
      ea = 0; ev = 0; ez = 0;
    end else begin
      ea = (e % 8) / 2;
      ev = (e > 0 && e % 8 == 0) ? 1 : 0;
      ez = (e < last) ? 1 : 0;
    end
    chk($sformatf("%s_adr_e%0d", nm, e), int'(adrA), ea);
    chk($sformatf("%s_vld_e%0d", nm, e), int'(validA), ev);
    chk($sformatf("%s_zau_e%0d", nm, e), int'(zauA), ez);
  endtask

  initial begin
    int nv;
    // single frame, kont=0, pattern 1010; row 0 and 11: stop in MIR is ignored
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0000};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 4'b0000};
    tbl[5]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b0000};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b1010};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1010};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b1010};

    rst = 1'b1;
    startA = 0; kontA = 0; stopA = 0; patA = 4'b1010;
    startB = 0; kontB = 0; stopB = 0; patB = 4'b0000;
    @(negedge clk);
    tick(); tick();
    chk("rst_adr", int'(adrA), 0);
    chk("rst_rij", int'(rijecA), 0);
    chk("rst_vld", int'(validA), 0);
    chk("rst_zau", int'(zauA), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      startA = tbl[i].start;
      stopA  = tbl[i].stop;
      tick();
      chk($sformatf("tbl%0d_adr", i), int'(adrA),   int'(tbl[i].adr));
      chk($sformatf("tbl%0d_vld", i), int'(validA), int'(tbl[i].vld));
      chk($sformatf("tbl%0d_zau", i), int'(zauA),   int'(tbl[i].zau));
      chk($sformatf("tbl%0d_rij", i), int'(rijecA), int'(tbl[i].rij));
    end
    startA = 0; stopA = 0;

    // reset in slot 2 discards the frame and clears rijec
    patA = 4'b0110;
    startA = 1; tick(); startA = 0;
    repeat (5) tick();
    chk("mid_adr_pre", int'(adrA), 2);
    rst = 1; tick(); rst = 0;
    chk("mid_adr", int'(adrA), 0);
    chk("mid_zau", int'(zauA), 0);
    chk("mid_rij", int'(rijecA), 0);
    chk("mid_vld", int'(validA), 0);
    nv = 0;
    repeat (12) begin tick(); if (validA) nv++; end
    chk("mid_novld", nv, 0);

    // fresh frame after reset
    patA = 4'b0011;
    startA = 1; tick(); startA = 0;
    chk_a("fresh", 0, 8);
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_a("fresh", e, 8);
      if (e == 8) chk("fresh_rij", int'(rijecA), 4'b0011);
    end

    // start re-asserted in slot 1 is ignored
    patA = 4'b1100;
    startA = 1; tick(); startA = 0;
    nv = 0;
    for (int e = 1; e <= 14; e++) begin
      startA = (e == 3);
      tick();
      if (validA) nv++;
      chk_a("busy", e, 8);
      if (e == 8) chk("busy_rij", int'(rijecA), 4'b1100);
    end
    startA = 0;
    chk("busy_nvld", nv, 1);

    // continuous: back-to-back frames with the pattern changed between them
    patA = 4'b0110; kontA = 1;
    startA = 1; tick(); startA = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk_a("cont", e, 1000);
      if (e == 8) begin chk("cont_rij1", int'(rijecA), 4'b0110); patA = 4'b1001; end
      if (e == 16) chk("cont_rij2", int'(rijecA), 4'b1001);
    end
    rst = 1; tick(); rst = 0;
    chk("cont_rst_zau", int'(zauA), 0);

    // stop pulsed in slot 1 of frame 2: frame 2 completes, no frame 3
    patA = 4'b0111;
    startA = 1; tick(); startA = 0;
    for (int e = 1; e <= 30; e++) begin
      stopA = (e == 11);
      tick();
      chk_a("stop", e, 16);
      if (e == 16) chk("stop_rij", int'(rijecA), 4'b0111);
    end
    stopA = 0;

    // start+stop together in MIR: stop ignored; stop on the frame-end edge counts
    patA = 4'b0101;
    startA = 1; stopA = 1; tick(); startA = 0; stopA = 0;
    for (int e = 1; e <= 24; e++) begin
      stopA = (e == 16);
      tick();
      chk_a("fend", e, 16);
      if (e == 16) chk("fend_rij", int'(rijecA), 4'b0101);
    end
    stopA = 0; kontA = 0;

    // 3 channels, 1 cycle per slot, continuous; address wraps 2->0
    patB = 4'b0101; kontB = 1;
    startB = 1; tick(); startB = 0;
    chk("B_adr_e0", int'(adrB), 0);
    for (int e = 1; e <= 12; e++) begin
      kontB = (e < 9);
      tick();
      if (e <= 9) begin
        chk($sformatf("B_adr_e%0d", e), int'(adrB), e % 3);
        chk($sformatf("B_vld_e%0d", e), int'(validB), (e % 3 == 0) ? 1 : 0);
        chk($sformatf("B_zau_e%0d", e), int'(zauB), (e < 9) ? 1 : 0);
      end else begin
        chk($sformatf("B_idle_e%0d", e), int'({adrB, validB, zauB}), 0);
      end
      if (e == 3) begin chk("B_rij1", int'(rijecB), 3'b101); patB = 4'b0011; end
      if (e == 6) chk("B_rij2", int'(rijecB), 3'b011);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
